data_memory: RTL and testbench

Data-memory responder on the far side of the Memory stage's load/store handshake. Accepts one request at a time on a valid/ready channel and inserts a programmable number of wait states. Returns the addressed aligned word on a second valid/ready response channel. Applies byte/halfword/word write enables for stores, and flags misaligned or out-of-range accesses instead of performing them.

---
 rtl/data_memory.sv | 191 +++++++++++++++++++
 tb/tb_data_memory.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// data_memory: word-organised data memory behind a valid/ready request channel
// and a valid/ready response channel, with a programmable number of wait states.
//
// Ports:
//   clk, rst       - clock and synchronous active-high reset
//   i_valid_mem    - request valid from the Memory stage
//   o_ready_dmem   - request can be accepted (registered)
//   i_addr         - byte address of the access
//   i_we           - 1 = store, 0 = load
//   i_func3        - access size (SB/SH/SW, LB/LH/LW/LBU/LHU)
//   i_wr_data      - right-aligned store data
//   o_valid_dmem   - response valid (registered)
//   i_ready_mem    - Memory stage accepts the response
//   o_read_data    - aligned word containing the address (loads only, else 0)
//   o_error        - access was misaligned, out of range or had a bad store size
//
// BASE_ADDR is assumed word aligned. Sign/zero extension is left to the requester.
module data_memory #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned LATENCY   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid_mem,
  output logic        o_ready_dmem,
  input  logic [31:0] i_addr,
  input  logic        i_we,
  input  logic [2:0]  i_func3,
  input  logic [31:0] i_wr_data,
  output logic        o_valid_dmem,
  input  logic        i_ready_mem,
  output logic [31:0] o_read_data,
  output logic        o_error
);

  localparam int unsigned AddrW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  LatMinus1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, wdata_q;
  logic        we_q;
  logic [2:0]  func3_q;
  logic        ready_q, valid_q, error_q;
  logic [31:0] rdata_q;

  logic [31:0] mem [DEPTH];

  logic        accept;
  logic        commit;

  // Decoded view of the request being committed.
  logic [31:0] req_addr, req_wdata;
  logic        req_we;
  logic [2:0]  req_func3;
  logic [29:0] word_off;
  logic [AddrW-1:0] idx;
  logic        below, beyond, misal, bad_store, err;
  logic [3:0]  be;
  logic [31:0] wd;

  assign accept = i_valid_mem & ready_q;
  // Entry to RESP is the single commit point; a reset on that edge cancels it.
  assign commit = (state_d == StResp) & (state_q != StResp) & ~rst;

  // With zero latency the commit edge is the accept edge, so decode the live inputs.
  always_comb begin
    if (state_q == StIdle) begin
      req_addr  = i_addr;
      req_wdata = i_wr_data;
      req_we    = i_we;
      req_func3 = i_func3;
    end else begin
      req_addr  = addr_q;
      req_wdata = wdata_q;
      req_we    = we_q;
      req_func3 = func3_q;
    end
  end

  always_comb begin
    word_off  = req_addr[31:2] - BASE_ADDR[31:2];
    idx       = word_off[AddrW-1:0];
    below     = req_addr < BASE_ADDR;
    beyond    = {2'b00, word_off} >= 32'(DEPTH);
    misal     = ((req_func3[1:0] == 2'b01) & req_addr[0]) |
                ((req_func3[1:0] == 2'b10) & (req_addr[1:0] != 2'b00));
    bad_store = req_we & !(req_func3 inside {3'b000, 3'b001, 3'b010});
    err       = below | beyond | misal | bad_store;
  end

  // Lane enables and lane-replicated store data.
  always_comb begin
    be = 4'b1111;
    wd = req_wdata;
    unique case (req_func3[1:0])
      2'b00: begin
        be = 4'b0001 << req_addr[1:0];
        wd = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be = req_addr[1] ? 4'b1100 : 4'b0011;
        wd = {2{req_wdata[15:0]}};
      end
      default: begin
        be = 4'b1111;
        wd = req_wdata;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (LATENCY > 0) begin
            state_d = StWait;
            cnt_d   = LatMinus1;
          end else begin
            state_d = StResp;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (valid_q & i_ready_mem) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      func3_q <= 3'b000;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d == StIdle);
      valid_q <= (state_d == StResp);
      if (accept) begin
        addr_q  <= i_addr;
        wdata_q <= i_wr_data;
        we_q    <= i_we;
        func3_q <= i_func3;
      end
      if (commit) begin
        error_q <= err;
        rdata_q <= (!req_we && !err) ? mem[idx] : 32'h0;
      end
    end
  end

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (commit && req_we && !err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem[idx][8*b +: 8] <= wd[8*b +: 8];
        end
      end
    end
  end

  assign o_ready_dmem = ready_q;
  assign o_valid_dmem = valid_q;
  assign o_read_data  = rdata_q;
  assign o_error      = error_q;

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory. Four instances with different LATENCY/BASE/DEPTH
// share the request/response stimulus; sel picks which one sees i_valid_mem and
// whose outputs are observed.
module tb_data_memory;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [31:0] addr, wdata;
  logic        we;
  logic [2:0]  f3;
  logic        ready_mem;
  logic [1:0]  sel;

  logic [3:0]  v_in;
  logic [3:0]  rdy_o, vld_o, err_o;
  logic [31:0] rd_o [4];
  logic        m_ready, m_valid, m_err;
  logic [31:0] m_rd;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 4; i++) v_in[i] = valid && (sel == 2'(i));
    m_ready = rdy_o[sel];
    m_valid = vld_o[sel];
    m_err   = err_o[sel];
    m_rd    = rd_o[sel];
  end

  // 0: LATENCY 0, base 0x1000, 16 words. 1: LATENCY 1. 2: LATENCY 3. 3: LATENCY 4.
  data_memory #(.DEPTH(16), .BASE_ADDR(32'h0000_1000), .LATENCY(0)) u_l0 (
    .clk(clk), .rst(rst), .i_valid_mem(v_in[0]), .o_ready_dmem(rdy_o[0]),
    .i_addr(addr), .i_we(we), .i_func3(f3), .i_wr_data(wdata),
    .o_valid_dmem(vld_o[0]), .i_ready_mem(ready_mem), .o_read_data(rd_o[0]),
    .o_error(err_o[0]));
  data_memory #(.DEPTH(4096), .BASE_ADDR(32'h0), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .i_valid_mem(v_in[1]), .o_ready_dmem(rdy_o[1]),
    .i_addr(addr), .i_we(we), .i_func3(f3), .i_wr_data(wdata),
    .o_valid_dmem(vld_o[1]), .i_ready_mem(ready_mem), .o_read_data(rd_o[1]),
    .o_error(err_o[1]));
  data_memory #(.DEPTH(4096), .BASE_ADDR(32'h0), .LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .i_valid_mem(v_in[2]), .o_ready_dmem(rdy_o[2]),
    .i_addr(addr), .i_we(we), .i_func3(f3), .i_wr_data(wdata),
    .o_valid_dmem(vld_o[2]), .i_ready_mem(ready_mem), .o_read_data(rd_o[2]),
    .o_error(err_o[2]));
  data_memory #(.DEPTH(4096), .BASE_ADDR(32'h0), .LATENCY(4)) u_l4 (
    .clk(clk), .rst(rst), .i_valid_mem(v_in[3]), .o_ready_dmem(rdy_o[3]),
    .i_addr(addr), .i_we(we), .i_func3(f3), .i_wr_data(wdata),
    .o_valid_dmem(vld_o[3]), .i_ready_mem(ready_mem), .o_read_data(rd_o[3]),
    .o_error(err_o[3]));

  // Issue one request and consume its response immediately.
  // lat counts falling edges after the accepting rising edge until valid is seen.
  task automatic do_req(input logic [31:0] a, input logic w, input logic [2:0] fn,
                        input logic [31:0] d, output logic [31:0] rd, output logic er,
                        output int lat, output logic to);
    int k;
    to = 1'b0; rd = '0; er = 1'b0; lat = 0;
    @(negedge clk);
    addr = a; we = w; f3 = fn; wdata = d; valid = 1'b1; ready_mem = 1'b0;
    k = 0;
    while (!m_ready && k < 50) begin @(negedge clk); k++; end
    if (!m_ready) begin to = 1'b1; valid = 1'b0; return; end
    @(negedge clk);
    valid = 1'b0;
    lat = 1;
    while (!m_valid && lat < 50) begin @(negedge clk); lat++; end
    if (!m_valid) begin to = 1'b1; return; end
    rd = m_rd; er = m_err; ready_mem = 1'b1;
    @(negedge clk);
    ready_mem = 1'b0;
  endtask

  task automatic test_reset();
    sel = 2'd1; rst = 1'b1; valid = 1'b0; ready_mem = 1'b0;
    addr = '0; wdata = '0; we = 1'b0; f3 = 3'b010;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({m_ready, m_valid, m_err, m_rd} !== 35'h0) begin
        bad++;
        $display("FAIL reset_outputs cycle %0d: got rdy=%b vld=%b err=%b rd=%h want all 0",
                 i, m_ready, m_valid, m_err, m_rd);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (m_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_ready: got %b want 1", m_ready);
    end
  endtask

  task automatic test_sw_lw();
    logic [31:0] rd; logic er, to; int lat;
    sel = 2'd1;
    do_req(32'h14, 1'b1, 3'b010, 32'h0000_0101, rd, er, lat, to);
    total++;
    if (to !== 1'b0 || lat !== 2) begin
      bad++; $display("FAIL sw_latency: got %0d (timeout %b) want 2", lat, to);
    end
    total++;
    if (er !== 1'b0 || rd !== 32'h0) begin
      bad++; $display("FAIL sw_resp: got err=%b rd=%h want err=0 rd=0", er, rd);
    end
    do_req(32'h14, 1'b0, 3'b010, 32'h0, rd, er, lat, to);
    total++;
    if (er !== 1'b0 || rd !== 32'h0000_0101) begin
      bad++; $display("FAIL lw_after_sw: got err=%b rd=%h want err=0 rd=00000101", er, rd);
    end
  endtask

  task automatic test_lanes();
    logic [31:0] rd; logic er, to; int lat;
    sel = 2'd1;
    do_req(32'h20, 1'b1, 3'b010, 32'hAABB_CCDD, rd, er, lat, to);
    do_req(32'h21, 1'b1, 3'b000, 32'h0000_0011, rd, er, lat, to);
    do_req(32'h20, 1'b0, 3'b010, 32'h0, rd, er, lat, to);
    total++;
    if (rd !== 32'hAABB_11DD) begin
      bad++; $display("FAIL sb_lane1: got %h want aabb11dd", rd);
    end
    do_req(32'h22, 1'b1, 3'b001, 32'h0000_3344, rd, er, lat, to);
    do_req(32'h20, 1'b0, 3'b010, 32'h0, rd, er, lat, to);
    total++;
    if (rd !== 32'h3344_11DD) begin
      bad++; $display("FAIL sh_upper: got %h want 334411dd", rd);
    end
    do_req(32'h23, 1'b1, 3'b000, 32'h0000_00EE, rd, er, lat, to);
    do_req(32'h23, 1'b0, 3'b100, 32'h0, rd, er, lat, to);
    total++;
    if (er !== 1'b0 || rd !== 32'hEE44_11DD) begin
      bad++; $display("FAIL sb_lane3_lbu: got err=%b rd=%h want err=0 rd=ee4411dd", er, rd);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er, to; int lat;
    sel = 2'd1;
    do_req(32'h2000, 1'b1, 3'b010, 32'h1234_5678, rd, er, lat, to);
    do_req(32'h2003, 1'b1, 3'b010, 32'hFFFF_FFFF, rd, er, lat, to);
    total++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      bad++; $display("FAIL sw_misaligned: got err=%b rd=%h want err=1 rd=0", er, rd);
    end
    do_req(32'h2000, 1'b0, 3'b010, 32'h0, rd, er, lat, to);
    total++;
    if (er !== 1'b0 || rd !== 32'h1234_5678) begin
      bad++; $display("FAIL word_unchanged: got err=%b rd=%h want err=0 rd=12345678", er, rd);
    end
    do_req(32'h0001, 1'b0, 3'b001, 32'h0, rd, er, lat, to);
    total++;
    if (er !== 1'b1) begin
      bad++; $display("FAIL lh_misaligned: got err=%b want 1", er);
    end
    do_req(32'h4000, 1'b0, 3'b010, 32'h0, rd, er, lat, to);
    total++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      bad++; $display("FAIL lw_out_of_range: got err=%b rd=%h want err=1 rd=0", er, rd);
    end
    do_req(32'h3FFC, 1'b0, 3'b010, 32'h0, rd, er, lat, to);
    total++;
    if (er !== 1'b0) begin
      bad++; $display("FAIL lw_last_word: got err=%b want 0", er);
    end
    do_req(32'h14, 1'b1, 3'b011, 32'hFFFF_FFFF, rd, er, lat, to);
    total++;
    if (er !== 1'b1) begin
      bad++; $display("FAIL bad_store_size: got err=%b want 1", er);
    end
    do_req(32'h16, 1'b0, 3'b001, 32'h0, rd, er, lat, to);
    total++;
    if (er !== 1'b0 || rd !== 32'h0000_0101) begin
      bad++; $display("FAIL lh_after_bad_store: got err=%b rd=%h want err=0 rd=00000101", er, rd);
    end
  endtask

  task automatic test_zero_latency_base();
    logic [31:0] rd; logic er, to; int lat;
    sel = 2'd0;
    do_req(32'h1008, 1'b1, 3'b010, 32'h0000_0077, rd, er, lat, to);
    total++;
    if (to !== 1'b0 || lat !== 1) begin
      bad++; $display("FAIL l0_latency: got %0d (timeout %b) want 1", lat, to);
    end
    do_req(32'h100B, 1'b1, 3'b000, 32'h0000_009A, rd, er, lat, to);
    do_req(32'h1008, 1'b0, 3'b010, 32'h0, rd, er, lat, to);
    total++;
    if (er !== 1'b0 || rd !== 32'h9A00_0077) begin
      bad++; $display("FAIL l0_readback: got err=%b rd=%h want err=0 rd=9a000077", er, rd);
    end
    do_req(32'h0FFC, 1'b0, 3'b010, 32'h0, rd, er, lat, to);
    total++;
    if (er !== 1'b1) begin
      bad++; $display("FAIL below_base: got err=%b want 1", er);
    end
    do_req(32'h1040, 1'b0, 3'b010, 32'h0, rd, er, lat, to);
    total++;
    if (er !== 1'b1) begin
      bad++; $display("FAIL past_end: got err=%b want 1", er);
    end
    do_req(32'h103C, 1'b0, 3'b010, 32'h0, rd, er, lat, to);
    total++;
    if (er !== 1'b0) begin
      bad++; $display("FAIL top_word: got err=%b want 0", er);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er, to; int lat, k;
    sel = 2'd2;
    do_req(32'h30, 1'b1, 3'b010, 32'h5A5A_1234, rd, er, lat, to);
    do_req(32'h34, 1'b1, 3'b010, 32'h0BAD_F00D, rd, er, lat, to);
    @(negedge clk);
    addr = 32'h30; we = 1'b0; f3 = 3'b010; valid = 1'b1; ready_mem = 1'b0;
    k = 0;
    while (!m_ready && k < 50) begin @(negedge clk); k++; end
    @(negedge clk);
    addr = 32'h34;  // requester keeps valid high with the next request
    lat = 1;
    while (!m_valid && lat < 50) begin @(negedge clk); lat++; end
    total++;
    if (lat !== 4) begin
      bad++; $display("FAIL l3_latency: got %0d want 4", lat);
    end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (m_valid !== 1'b1 || m_rd !== 32'h5A5A_1234 || m_err !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold %0d: got vld=%b rd=%h err=%b want vld=1 rd=5a5a1234 err=0",
                 i, m_valid, m_rd, m_err);
      end
      if (i < 4) @(negedge clk);
    end
    ready_mem = 1'b1;
    @(negedge clk);
    ready_mem = 1'b0;
    total++;
    if (m_valid !== 1'b0 || m_ready !== 1'b1) begin
      bad++; $display("FAIL after_handshake: got vld=%b rdy=%b want vld=0 rdy=1", m_valid, m_ready);
    end
    @(negedge clk);
    valid = 1'b0;
    total++;
    if (m_ready !== 1'b0) begin
      bad++; $display("FAIL second_accept: got rdy=%b want 0", m_ready);
    end
    lat = 1;
    while (!m_valid && lat < 50) begin @(negedge clk); lat++; end
    total++;
    if (lat !== 4 || m_rd !== 32'h0BAD_F00D) begin
      bad++; $display("FAIL second_resp: got lat=%0d rd=%h want lat=4 rd=0badf00d", lat, m_rd);
    end
    ready_mem = 1'b1;
    @(negedge clk);
    ready_mem = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] rd; logic er, to; int lat, k, seen;
    sel = 2'd3;
    do_req(32'h40, 1'b1, 3'b010, 32'h0123_4567, rd, er, lat, to);
    @(negedge clk);
    addr = 32'h40; we = 1'b1; f3 = 3'b010; wdata = 32'hDEAD_BEEF; valid = 1'b1;
    k = 0;
    while (!m_ready && k < 50) begin @(negedge clk); k++; end
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (m_valid !== 1'b0 || m_ready !== 1'b0) begin
      bad++; $display("FAIL wait_reset_outputs: got vld=%b rdy=%b want 0 0", m_valid, m_ready);
    end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (m_valid) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++; $display("FAIL dropped_resp: got %0d valid cycles want 0", seen);
    end
    do_req(32'h40, 1'b0, 3'b010, 32'h0, rd, er, lat, to);
    total++;
    if (to !== 1'b0 || rd !== 32'h0123_4567) begin
      bad++; $display("FAIL no_write_on_reset: got rd=%h (timeout %b) want 01234567", rd, to);
    end
  endtask

  initial begin
    test_reset();
    test_sw_lw();
    test_lanes();
    test_errors();
    test_zero_latency_base();
    test_back_to_back();
    test_reset_in_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
